// File: rtl/issue_queue_pkg.sv
// Shared sizing, entry layout and wakeup-match helper for the issue queue.
package iq_pkg;

  localparam int DEPTH     = 32;
  localparam int TAG_W     = 6;
  localparam int PAYLOAD_W = 32;
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     src1;
    logic                 src1_rdy;
    logic [TAG_W-1:0]     src2;
    logic                 src2_rdy;
    logic [TAG_W-1:0]     dst;
    logic [PAYLOAD_W-1:0] payload;
  } iq_entry_t;

  // True when either wakeup port broadcasts a tag matching this source.
  function automatic logic wk_hit(input logic [1:0]       wkv,
                                  input logic [TAG_W-1:0] t0,
                                  input logic [TAG_W-1:0] t1,
                                  input logic [TAG_W-1:0] tag);
    return (wkv[0] && (t0 == tag)) || (wkv[1] && (t1 == tag));
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Dispatch, wakeup, issue and flush signals of the issue queue; master drives dispatch/wakeup.
interface issue_queue_if #(
  parameter int DEPTH     = iq_pkg::DEPTH,
  parameter int TAG_W     = iq_pkg::TAG_W,
  parameter int PAYLOAD_W = iq_pkg::PAYLOAD_W
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [TAG_W-1:0]     in_src1;
  logic [TAG_W-1:0]     in_src2;
  logic                 in_src1_rdy;
  logic                 in_src2_rdy;
  logic [TAG_W-1:0]     in_dst;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [1:0]           wk_valid;
  logic [TAG_W-1:0]     wk_tag0;
  logic [TAG_W-1:0]     wk_tag1;
  logic                 out_valid;
  logic                 out_ready;
  logic [AW-1:0]        out_addr;
  logic [TAG_W-1:0]     out_dst;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [CW-1:0]        count;

  modport master (
    output flush, in_valid, in_src1, in_src2, in_src1_rdy, in_src2_rdy,
           in_dst, in_payload, wk_valid, wk_tag0, wk_tag1, out_ready,
    input  in_ready, out_valid, out_addr, out_dst, out_payload, count
  );

  modport slave (
    input  flush, in_valid, in_src1, in_src2, in_src1_rdy, in_src2_rdy,
           in_dst, in_payload, wk_valid, wk_tag0, wk_tag1, out_ready,
    output in_ready, out_valid, out_addr, out_dst, out_payload, count
  );

endinterface

// File: rtl/issue_queue_select_tree.sv
// Lowest-index priority picker: log2(DEPTH) levels of 2-input request/address combine cells.
module iq_sel_cell #(
  parameter int AW  = 5,
  parameter int LVL = 0
) (
  input  logic          i_v_lo,
  input  logic          i_v_hi,
  input  logic [AW-1:0] i_a_lo,
  input  logic [AW-1:0] i_a_hi,
  output logic          o_v,
  output logic [AW-1:0] o_a
);
  // Low half wins; picking the high half sets this level's address bit.
  assign o_v = i_v_lo | i_v_hi;
  assign o_a = i_v_lo ? i_a_lo : (i_a_hi | AW'(1 << LVL));
endmodule

module iq_select_tree #(
  parameter int DEPTH = 32
) (
  input  logic [DEPTH-1:0]         i_req,
  output logic                     o_valid,
  output logic [$clog2(DEPTH)-1:0] o_addr
);
  localparam int AW = $clog2(DEPTH);

  logic          w_v [AW+1][DEPTH];
  logic [AW-1:0] w_a [AW+1][DEPTH];

  for (genvar j = 0; j < DEPTH; j++) begin : g_leaf
    assign w_v[0][j] = i_req[j];
    assign w_a[0][j] = '0;
  end

  for (genvar l = 0; l < AW; l++) begin : g_lvl
    for (genvar j = 0; j < DEPTH; j++) begin : g_node
      if (j < (DEPTH >> (l + 1))) begin : g_cell
        iq_sel_cell #(.AW(AW), .LVL(l)) u_cell (
          .i_v_lo (w_v[l][2*j]),
          .i_v_hi (w_v[l][2*j+1]),
          .i_a_lo (w_a[l][2*j]),
          .i_a_hi (w_a[l][2*j+1]),
          .o_v    (w_v[l+1][j]),
          .o_a    (w_a[l+1][j])
        );
      end else begin : g_tie
        assign w_v[l+1][j] = 1'b0;
        assign w_a[l+1][j] = '0;
      end
    end
  end

  assign o_valid = w_v[AW][0];
  assign o_addr  = w_a[AW][0];
endmodule

// File: rtl/issue_queue.sv
// Wakeup/select issue queue. Define IQ_SPEC_WAKEUP_EN to let same-cycle wakeups count
// toward issue eligibility; otherwise only registered ready bits are used.
module issue_queue #(
  parameter int DEPTH     = iq_pkg::DEPTH,
  parameter int TAG_W     = iq_pkg::TAG_W,
  parameter int PAYLOAD_W = iq_pkg::PAYLOAD_W
) (
  input  logic          clk,
  input  logic          rst,
  issue_queue_if.slave  bus
);
  import iq_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  iq_entry_t        r_ent [DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_hit1, w_hit2, w_elig, w_free;
  logic             w_any_elig, w_any_free;
  logic [AW-1:0]    w_sel, w_free_addr;
  logic             w_in_ready, w_disp, w_iss;
  logic             w_in_hit1, w_in_hit2;

  always_comb begin
    w_hit1 = '0;
    w_hit2 = '0;
    w_elig = '0;
    w_free = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit1[i] = wk_hit(bus.wk_valid, bus.wk_tag0, bus.wk_tag1, r_ent[i].src1);
      w_hit2[i] = wk_hit(bus.wk_valid, bus.wk_tag0, bus.wk_tag1, r_ent[i].src2);
      w_free[i] = !r_ent[i].valid;
`ifdef IQ_SPEC_WAKEUP_EN
      w_elig[i] = r_ent[i].valid && (r_ent[i].src1_rdy || w_hit1[i])
                                 && (r_ent[i].src2_rdy || w_hit2[i]);
`else
      w_elig[i] = r_ent[i].valid && r_ent[i].src1_rdy && r_ent[i].src2_rdy;
`endif
    end
  end

  iq_select_tree #(.DEPTH(DEPTH)) u_iss_sel (
    .i_req   (w_elig),
    .o_valid (w_any_elig),
    .o_addr  (w_sel)
  );

  iq_select_tree #(.DEPTH(DEPTH)) u_free_sel (
    .i_req   (w_free),
    .o_valid (w_any_free),
    .o_addr  (w_free_addr)
  );

  // Readiness looks only at registered occupancy, never at a same-cycle issue.
  assign w_in_ready = !rst && !bus.flush && (r_count < CW'(DEPTH));
  assign w_disp     = bus.in_valid && w_in_ready && w_any_free;
  assign w_iss      = w_any_elig && bus.out_ready;
  assign w_in_hit1  = wk_hit(bus.wk_valid, bus.wk_tag0, bus.wk_tag1, bus.in_src1);
  assign w_in_hit2  = wk_hit(bus.wk_valid, bus.wk_tag0, bus.wk_tag1, bus.in_src2);

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_ent[i].valid && w_hit1[i]) r_ent[i].src1_rdy <= 1'b1;
        if (r_ent[i].valid && w_hit2[i]) r_ent[i].src2_rdy <= 1'b1;
        if (w_iss && (w_sel == AW'(i))) r_ent[i].valid <= 1'b0;
        // The free slot is never the issuing one, so these writes cannot collide.
        if (w_disp && (w_free_addr == AW'(i)))
          r_ent[i] <= '{valid:    1'b1,
                        src1:     bus.in_src1,
                        src1_rdy: bus.in_src1_rdy || w_in_hit1,
                        src2:     bus.in_src2,
                        src2_rdy: bus.in_src2_rdy || w_in_hit2,
                        dst:      bus.in_dst,
                        payload:  bus.in_payload};
      end
      r_count <= r_count + CW'(w_disp) - CW'(w_iss);
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_any_elig;
  assign bus.out_addr    = w_sel;
  assign bus.out_dst     = r_ent[w_sel].dst;
  assign bus.out_payload = r_ent[w_sel].payload;
  assign bus.count       = r_count;

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboarded random + directed bench for issue_queue against a slot-array reference model.
module tb_issue_queue;
  localparam int D = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_queue_if bus ();

  issue_queue u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit        v;
    bit [5:0]  s1;
    bit        r1;
    bit [5:0]  s2;
    bit        r2;
    bit [5:0]  dst;
    bit [31:0] pl;
  } ment_t;

  typedef struct {
    bit        rdy;
    int        cnt;
    bit        ov;
    int        addr;
    bit [5:0]  dst;
    bit [31:0] pl;
  } exp_t;

  ment_t m [D];
  exp_t  sbq [$];
  int    checks   = 0;
  int    failures = 0;

  function automatic bit hit(bit [5:0] t);
    return (bus.wk_valid[0] && bus.wk_tag0 == t) || (bus.wk_valid[1] && bus.wk_tag1 == t);
  endfunction

  function automatic bit elig(int i);
    bit a, b;
    a = m[i].r1;
    b = m[i].r2;
`ifdef IQ_SPEC_WAKEUP_EN
    a = a || hit(m[i].s1);
    b = b || hit(m[i].s2);
`endif
    return m[i].v && a && b;
  endfunction

  function automatic int pick();
    for (int i = 0; i < D; i++) if (elig(i)) return i;
    return -1;
  endfunction

  function automatic int occupied();
    int n = 0;
    for (int i = 0; i < D; i++) if (m[i].v) n++;
    return n;
  endfunction

  function automatic int first_free();
    for (int i = 0; i < D; i++) if (!m[i].v) return i;
    return -1;
  endfunction

  task automatic push_exp();
    exp_t e;
    int s;
    s      = pick();
    e.rdy  = !rst && !bus.flush && (occupied() < D);
    e.cnt  = occupied();
    e.ov   = (s >= 0);
    e.addr = (s >= 0) ? s : 0;
    e.dst  = (s >= 0) ? m[s].dst : 6'd0;
    e.pl   = (s >= 0) ? m[s].pl : 32'd0;
    sbq.push_back(e);
  endtask

  // Advance the model by one edge using the inputs still held on the bus.
  task automatic model_edge();
    int s, f;
    bit di, is;
    if (rst || bus.flush) begin
      for (int i = 0; i < D; i++) m[i].v = 1'b0;
      return;
    end
    s  = pick();
    f  = first_free();
    is = (s >= 0) && bus.out_ready;
    di = bus.in_valid && (occupied() < D);
    for (int i = 0; i < D; i++) begin
      if (m[i].v && hit(m[i].s1)) m[i].r1 = 1'b1;
      if (m[i].v && hit(m[i].s2)) m[i].r2 = 1'b1;
    end
    if (is) m[s].v = 1'b0;
    if (di) begin
      m[f].v   = 1'b1;
      m[f].s1  = bus.in_src1;
      m[f].r1  = bus.in_src1_rdy || hit(bus.in_src1);
      m[f].s2  = bus.in_src2;
      m[f].r2  = bus.in_src2_rdy || hit(bus.in_src2);
      m[f].dst = bus.in_dst;
      m[f].pl  = bus.in_payload;
    end
  endtask

  task automatic step();
    push_exp();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_src1     = '0;
    bus.in_src2     = '0;
    bus.in_src1_rdy = 1'b0;
    bus.in_src2_rdy = 1'b0;
    bus.in_dst      = '0;
    bus.in_payload  = '0;
    bus.wk_valid    = '0;
    bus.wk_tag0     = '0;
    bus.wk_tag1     = '0;
    bus.out_ready   = 1'b0;
  endtask

  task automatic disp(bit [5:0] s1, bit r1, bit [5:0] s2, bit r2, bit [5:0] dst, bit [31:0] pl);
    bus.in_valid    = 1'b1;
    bus.in_src1     = s1;
    bus.in_src1_rdy = r1;
    bus.in_src2     = s2;
    bus.in_src2_rdy = r2;
    bus.in_dst      = dst;
    bus.in_payload  = pl;
  endtask

  task automatic do_flush();
    idle();
    bus.flush = 1'b1;
    step();
    idle();
  endtask

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("in_ready", 32'(bus.in_ready), 32'(e.rdy));
      chk("count", 32'(bus.count), e.cnt);
      chk("out_valid", 32'(bus.out_valid), 32'(e.ov));
      if (e.ov) begin
        chk("out_addr", 32'(bus.out_addr), e.addr);
        chk("out_dst", 32'(bus.out_dst), 32'(e.dst));
        chk("out_payload", bus.out_payload, e.pl);
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // Ready-at-dispatch op issues the following cycle.
    disp(6'd1, 1'b1, 6'd2, 1'b1, 6'd5, 32'hA5A5_0001);
    step();
    idle();
    bus.out_ready = 1'b1;
    step();
    idle();
    step();

    // Wakeup on port 0 two cycles after dispatch.
    disp(6'd12, 1'b0, 6'd3, 1'b1, 6'd7, 32'h0000_1212);
    step();
    idle();
    step();
    bus.wk_valid = 2'b01;
    bus.wk_tag0  = 6'd12;
    bus.out_ready = 1'b1;
    step();
    idle();
    bus.out_ready = 1'b1;
    step();
    step();

    // Dispatch-cycle wakeup on port 1 captured into the stored ready bit.
    idle();
    disp(6'd4, 1'b1, 6'd9, 1'b0, 6'd9, 32'h0000_0909);
    bus.wk_valid = 2'b10;
    bus.wk_tag1  = 6'd9;
    step();
    idle();
    bus.out_ready = 1'b1;
    step();
    step();

    // Fill to full with out_ready low, then release one.
    do_flush();
    for (int i = 0; i < D + 1; i++) begin
      disp(6'd0, 1'b1, 6'd0, 1'b1, 6'(i), 32'h1000_0000 + 32'(i));
      step();
    end
    idle();
    bus.out_ready = 1'b1;
    step();
    idle();
    step();
    step();

    // Only entries 3 and 7 eligible.
    do_flush();
    for (int i = 0; i < 8; i++) begin
      disp(6'd40, (i == 3 || i == 7), 6'd41, 1'b1, 6'(20 + i), 32'h3000_0000 + 32'(i));
      step();
    end
    idle();
    step();
    bus.out_ready = 1'b1;
    step();
    step();
    idle();
    step();

    // Flush with count at 10 overrides a concurrent dispatch.
    do_flush();
    for (int i = 0; i < 10; i++) begin
      disp(6'd50, 1'b0, 6'd51, 1'b1, 6'(i), 32'(i));
      step();
    end
    idle();
    step();
    disp(6'd1, 1'b1, 6'd1, 1'b1, 6'd33, 32'hDEAD_0033);
    bus.flush = 1'b1;
    step();
    idle();
    step();

    // Reset mid-operation with out_ready high drops everything.
    for (int i = 0; i < 4; i++) begin
      disp(6'd2, 1'b1, 6'd2, 1'b1, 6'(i), 32'h4000_0000 + 32'(i));
      step();
    end
    idle();
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();

    for (int c = 0; c < 3000; c++) begin
      int mode;
      mode = c / 300;
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.in_src1     = 6'($urandom_range(0, 15));
      bus.in_src2     = 6'($urandom_range(0, 15));
      bus.in_src1_rdy = ($urandom_range(0, 2) == 0);
      bus.in_src2_rdy = ($urandom_range(0, 2) == 0);
      bus.in_dst      = 6'($urandom_range(0, 63));
      bus.in_payload  = $urandom;
      bus.wk_valid    = 2'($urandom_range(0, 3));
      bus.wk_tag0     = 6'($urandom_range(0, 15));
      bus.wk_tag1     = 6'($urandom_range(0, 15));
      bus.out_ready   = (mode % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      bus.flush       = ($urandom_range(0, 149) == 0);
      rst             = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    step();
    step();

    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
